// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
package sfifo_pkg;

  // Bit positions inside the write-1-to-clear error vector
  localparam int ERR_OV = 0;
  localparam int ERR_UD = 1;

  // Pointer increment that wraps at an arbitrary depth rather than at 2^n
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sfifo_flex_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, asynchronous read port.
module sfifo_flex_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  wclk,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write pointer; contents need no reset
  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sfifo_flex.sv
// Single-clock FIFO with arbitrary depth, occupancy/threshold status,
// sticky error flags, high-water mark, flush and optional output register.
module sfifo_flex
  import sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int OUT_REG    = 0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  sfifo_full,
  output logic                  sfifo_empty,
  output logic [CNT_W-1:0]      count,
  input  logic [CNT_W-1:0]      af_th,
  input  logic [CNT_W-1:0]      ae_th,
  output logic                  sfifo_almost_full,
  output logic                  sfifo_almost_empty,
  input  logic [1:0]            err_clr,
  output logic                  sfifo_ov,
  output logic                  sfifo_ud,
  output logic [CNT_W-1:0]      hwm
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [CNT_W-1:0]      hwm_q, hwm_nxt;
  logic                  ov_q, ov_nxt;
  logic                  ud_q, ud_nxt;
  logic                  full, empty;
  logic                  we, re;
  logic [DATA_WIDTH-1:0] rdata;

  // Accepts depend only on registered occupancy; flush overrides both
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);
  assign we    = wr & ~full & ~flush;
  assign re    = rd & ~empty & ~flush;

  // Next occupancy, sticky error flags and high-water mark
  always_comb begin
    cnt_nxt = cnt_q;
    if (flush)           cnt_nxt = '0;
    else if (we && !re)  cnt_nxt = cnt_q + 1'b1;
    else if (re && !we)  cnt_nxt = cnt_q - 1'b1;

    ov_nxt = ov_q;
    if (err_clr[ERR_OV])       ov_nxt = 1'b0;
    if (wr && full && !flush)  ov_nxt = 1'b1;

    ud_nxt = ud_q;
    if (err_clr[ERR_UD])       ud_nxt = 1'b0;
    if (rd && empty && !flush) ud_nxt = 1'b1;

    if (err_clr != 2'b00)      hwm_nxt = cnt_nxt;
    else if (cnt_nxt > hwm_q)  hwm_nxt = cnt_nxt;
    else                       hwm_nxt = hwm_q;
  end

  // Control state: pointers, occupancy and status registers
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
      ud_q   <= 1'b0;
      hwm_q  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (we) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
        if (re) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
      end
      cnt_q <= cnt_nxt;
      ov_q  <= ov_nxt;
      ud_q  <= ud_nxt;
      hwm_q <= hwm_nxt;
    end
  end

  sfifo_flex_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .wclk  (wclk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] dout_p1;
      logic                  vld_p1;

      // Stage p1: capture the head word on an accepted read
      always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= re;
          if (re) dout_p1 <= rdata;
        end
      end

      assign data_out = dout_p1;
      assign rd_valid = vld_p1;
    end else begin : g_comb
      assign data_out = rdata;
      assign rd_valid = re;
    end
  endgenerate

  assign sfifo_full         = full;
  assign sfifo_empty        = empty;
  assign count              = cnt_q;
  assign sfifo_ov           = ov_q;
  assign sfifo_ud           = ud_q;
  assign hwm                = hwm_q;
  assign sfifo_almost_full  = (cnt_q >= af_th);
  assign sfifo_almost_empty = (cnt_q <= ae_th);

endmodule
